// File: rtl/matrix_streamer.sv
// matrix_streamer
//
// Streams one frame of LED-matrix rows from the framebuffer (BRAM port B) to
// the Arduino matrix driver. A rising edge on frame_req starts a frame; each of
// the ROWS row words is read, shifted out MSB-first on ser_clk/ser_data and
// followed by a row_latch pulse. frame_abort (level) returns the block to IDLE.
//
// Optional feature: define MATRIX_STREAMER_PARITY_EN to append an odd-parity
// bit after bit 0 of every row (17 bits per row instead of 16).
//
// Parameters:
//   BASE_ADDR   port-B address of framebuffer row 0
//   ROWS        rows per frame (1..16)
//   CLK_DIV     clk cycles per serial half-period (1..255)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   frame_req    in   asynchronous frame request (rising edge)
//   frame_abort  in   asynchronous level-sensitive abort
//   addr_b       out  registered BRAM port-B read address
//   q_b          in   BRAM port-B read data (one cycle after address)
//   ser_clk      out  serial clock
//   ser_data     out  serial data, changes only while ser_clk is low
//   row_latch    out  high for CLK_DIV cycles after each row
//   busy         out  high in every state except IDLE
//   frame_done   out  one-cycle pulse after the last row latch
//   row_idx      out  index of the row being streamed
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a synchronized request edge
// FETCH   | addr_b presented, BRAM captures it this cycle
// WAIT    | q_b becomes valid; loaded into the shift register on exit
// SHIFT   | CLK_DIV cycles ser_clk low, CLK_DIV cycles high, per bit
// LATCH   | row_latch high for CLK_DIV cycles, then next row or DONE
// DONE    | frame_done pulse, back to IDLE

module matrix_streamer #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned ROWS      = 16,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_req,
    input  logic        frame_abort,
    output logic [15:0] addr_b,
    input  logic [15:0] q_b,
    output logic        ser_clk,
    output logic        ser_data,
    output logic        row_latch,
    output logic        busy,
    output logic        frame_done,
    output logic [3:0]  row_idx
);

`ifdef MATRIX_STREAMER_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [4:0] BIT_LAST = 5'(NBITS - 1);

    // two-flop synchronizers; req_s3_q is the delayed copy for edge detect
    logic req_s1_q, req_s2_q, req_s3_q;
    logic abt_s1_q, abt_s2_q;
    logic req_pulse;

    logic [2:0]       state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic             phase_q, phase_d;
    logic [4:0]       bit_q, bit_d;
    logic [NBITS-1:0] sh_q, sh_d;
    logic [3:0]       row_q, row_d;
    logic [15:0]      addr_q, addr_d;
    logic             div_last;
    logic [NBITS-1:0] load_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            req_s3_q <= 1'b0;
            abt_s1_q <= 1'b0;
            abt_s2_q <= 1'b0;
        end else begin
            req_s1_q <= frame_req;
            req_s2_q <= req_s1_q;
            req_s3_q <= req_s2_q;
            abt_s1_q <= frame_abort;
            abt_s2_q <= abt_s1_q;
        end
    end

    assign req_pulse = req_s2_q & ~req_s3_q;

`ifdef MATRIX_STREAMER_PARITY_EN
    // odd parity: total number of ones across the 17 bits is odd
    assign load_word = {q_b, ~(^q_b)};
`else
    assign load_word = q_b;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        row_d    = row_q;
        addr_d   = addr_q;
        div_last = (div_q == DIV_LAST);

        if (abt_s2_q) begin
            // abort wins over everything, including a request in the same cycle
            state_d = S_IDLE;
            div_d   = 8'd0;
            phase_d = 1'b0;
            bit_d   = 5'd0;
            sh_d    = '0;
            row_d   = 4'd0;
            addr_d  = BASE_ADDR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_pulse) begin
                        state_d = S_FETCH;
                        row_d   = 4'd0;
                        addr_d  = BASE_ADDR;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    state_d = S_SHIFT;
                    sh_d    = load_word;
                    bit_d   = 5'd0;
                    div_d   = 8'd0;
                    phase_d = 1'b0;
                end
                S_SHIFT: begin
                    if (div_last) begin
                        div_d = 8'd0;
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            // end of high phase: advance to the next bit
                            phase_d = 1'b0;
                            sh_d    = {sh_q[NBITS-2:0], 1'b0};
                            bit_d   = bit_q + 5'd1;
                            if (bit_q == BIT_LAST) begin
                                state_d = S_LATCH;
                                bit_d   = 5'd0;
                            end
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                S_LATCH: begin
                    if (div_last) begin
                        div_d = 8'd0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 4'd1;
                            addr_d  = addr_q + 16'd1;   // wraps modulo 2^16
                            state_d = S_FETCH;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= 8'd0;
            phase_q <= 1'b0;
            bit_q   <= 5'd0;
            sh_q    <= '0;
            row_q   <= 4'd0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
        end
    end

    assign addr_b     = addr_q;
    assign row_idx    = row_q;
    assign ser_clk    = (state_q == S_SHIFT) & phase_q;
    assign ser_data   = (state_q == S_SHIFT) & sh_q[NBITS-1];
    assign row_latch  = (state_q == S_LATCH);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_streamer.sv
module tb_matrix_streamer;

`ifdef MATRIX_STREAMER_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif
    localparam int DIV0       = 4;
    localparam int ROWS0      = 16;
    localparam int ROW_CYC0   = 2 + NB * 2 * DIV0 + DIV0;
    localparam int FRAME_CYC0 = ROWS0 * ROW_CYC0 + 1;
    localparam int ROW_CYC1   = 2 + NB * 2 * 1 + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_req0 = 1'b0, frame_abort0 = 1'b0;
    logic frame_req1 = 1'b0, frame_abort1 = 1'b0;
    logic [15:0] addr_b0, addr_b1, q_b0, q_b1;
    logic ser_clk0, ser_data0, row_latch0, busy0, frame_done0;
    logic ser_clk1, ser_data1, row_latch1, busy1, frame_done1;
    logic [3:0] row_idx0, row_idx1;
    logic [15:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // synchronous-read BRAM model: data valid one cycle after the address
    always @(posedge clk) begin
        q_b0 <= mem[addr_b0];
        q_b1 <= mem[addr_b1];
    end

    matrix_streamer dut0 (
        .clk(clk), .reset(reset), .frame_req(frame_req0), .frame_abort(frame_abort0),
        .addr_b(addr_b0), .q_b(q_b0), .ser_clk(ser_clk0), .ser_data(ser_data0),
        .row_latch(row_latch0), .busy(busy0), .frame_done(frame_done0), .row_idx(row_idx0)
    );

    matrix_streamer #(.BASE_ADDR(16'hFFFF), .ROWS(2), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .frame_req(frame_req1), .frame_abort(frame_abort1),
        .addr_b(addr_b1), .q_b(q_b1), .ser_clk(ser_clk1), .ser_data(ser_data1),
        .row_latch(row_latch1), .busy(busy1), .frame_done(frame_done1), .row_idx(row_idx1)
    );

    // ---------------- serial receiver for dut0 (Arduino side) ----------------
    logic          prev_sclk = 1'b0, prev_sdat = 1'b0, prev_latch = 1'b0;
    logic [NB-1:0] cap = '0;
    int            nbits = 0;
    int            latch_cnt = 0, done_cnt = 0, stab_err = 0;
    logic [NB-1:0] cap_q [$];
    int            nb_q  [$];
    logic [15:0]   ad_q  [$];
    logic [3:0]    ri_q  [$];

    always @(negedge clk) begin
        if (reset || !busy0) begin
            cap   <= '0;
            nbits <= 0;
        end else begin
            if (ser_clk0 && !prev_sclk) begin
                cap   <= {cap[NB-2:0], ser_data0};
                nbits <= nbits + 1;
            end
            if (row_latch0 && !prev_latch) begin
                cap_q.push_back(cap);
                nb_q.push_back(nbits);
                ad_q.push_back(addr_b0);
                ri_q.push_back(row_idx0);
                cap   <= '0;
                nbits <= 0;
            end
        end
        if (!reset && ser_clk0 && (ser_data0 !== prev_sdat)) stab_err <= stab_err + 1;
        if (!reset && ser_data0 && (!busy0 || row_latch0))   stab_err <= stab_err + 1;
        if (row_latch0 && !prev_latch) latch_cnt <= latch_cnt + 1;
        if (frame_done0) done_cnt <= done_cnt + 1;
        prev_sclk  <= ser_clk0;
        prev_sdat  <= ser_data0;
        prev_latch <= row_latch0;
    end

    // ---------------- reference data ----------------
    typedef struct {
        logic [15:0] word;
        bit          par;   // odd-parity bit expected after bit 0
    } vec_t;

    vec_t        tbl [16];
    logic [15:0] exp_word [16];
    bit          exp_par  [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rows(input int base);
        int          avail;
        logic [16:0] full;
        logic [NB-1:0] e;
        avail = cap_q.size() - base;
        check("latch_count", avail, ROWS0);
        if (avail >= ROWS0) begin
            for (int r = 0; r < ROWS0; r++) begin
                full = {exp_word[r], exp_par[r]};
                e    = NB'(full >> (17 - NB));
                check($sformatf("row%0d_bits", r), 32'(cap_q[base + r]), 32'(e));
                check($sformatf("row%0d_nbits", r), nb_q[base + r], NB);
                check($sformatf("row%0d_addr", r), 32'(ad_q[base + r]), r);
                check($sformatf("row%0d_idx", r), 32'(ri_q[base + r]), r);
            end
        end
    endtask

    task automatic run_frame0(input int extra, output int lat, output int cyc,
                              output logic [15:0] a0, output logic [3:0] r0);
        @(posedge clk);
        #1 frame_req0 = 1'b1;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (busy0) break;
        end
        a0 = addr_b0;
        r0 = row_idx0;
        frame_req0 = 1'b0;
        cyc = 1;
        while (!frame_done0 && cyc < FRAME_CYC0 + 200) begin
            @(negedge clk);
            cyc++;
            frame_req0 = (extra > 0) && (cyc >= 20) && (cyc < 20 + 20 * extra) && ((cyc / 10) % 2 == 0);
        end
        frame_req0 = 1'b0;
    endtask

    task automatic do_frame(input int extra);
        int base, d0, lat, cyc;
        logic [15:0] a0;
        logic [3:0]  r0;
        base = cap_q.size();
        d0   = done_cnt;
        run_frame0(extra, lat, cyc, a0, r0);
        // request sampled at edge N, FETCH at N+2: seen on the 4th falling edge after raising
        check("req_latency", lat, 4);
        check("start_addr", 32'(a0), 0);
        check("start_row", 32'(r0), 0);
        check("done_cycle", cyc, FRAME_CYC0);
        repeat (30) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("idle_after", 32'(busy0), 0);
        check_rows(base);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int k, d0;
        tbl[0]  = '{16'hA5A5, 1'b1}; tbl[1]  = '{16'h0001, 1'b0};
        tbl[2]  = '{16'h0003, 1'b1}; tbl[3]  = '{16'h0007, 1'b0};
        tbl[4]  = '{16'hFFFF, 1'b1}; tbl[5]  = '{16'h0000, 1'b1};
        tbl[6]  = '{16'h8000, 1'b0}; tbl[7]  = '{16'h7FFF, 1'b0};
        tbl[8]  = '{16'h1234, 1'b0}; tbl[9]  = '{16'h5555, 1'b1};
        tbl[10] = '{16'h00FF, 1'b1}; tbl[11] = '{16'h0F0F, 1'b1};
        tbl[12] = '{16'hC001, 1'b0}; tbl[13] = '{16'h1111, 1'b1};
        tbl[14] = '{16'h8421, 1'b1}; tbl[15] = '{16'hFFFE, 1'b0};
        for (int r = 0; r < 16; r++) begin
            mem[r]      = tbl[r].word;
            exp_word[r] = tbl[r].word;
            exp_par[r]  = tbl[r].par;
        end
        mem[16'hFFFF] = 16'h3C3C;

        // reset values
        #23;
        check("rst_outs0", {ser_clk0, ser_data0, row_latch0, busy0, frame_done0, row_idx0}, 0);
        check("rst_addr0", 32'(addr_b0), 0);
        check("rst_outs1", {ser_clk1, ser_data1, row_latch1, busy1, frame_done1, row_idx1}, 0);
        check("rst_addr1", 32'(addr_b1), 32'h0000FFFF);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // table-driven frame
        do_frame(0);

        // randomized frames against the arithmetic model; the second one gets
        // three extra request pulses that must be dropped
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 16; r++) begin
                mem[r]      = 16'($urandom);
                exp_word[r] = mem[r];
                exp_par[r]  = ($countones(mem[r]) % 2) == 0;
            end
            do_frame(f == 1 ? 3 : 0);
        end

        // abort at bit 7 of row 3
        d0 = done_cnt;
        @(posedge clk);
        #1 frame_req0 = 1'b1;
        k = 0;
        while (k < 12) begin @(negedge clk); k++; if (busy0) break; end
        frame_req0 = 1'b0;
        k = 0;
        while (k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (row_idx0 == 4'd3 && nbits == 7) break;
        end
        check("abort_reached", {row_idx0, 4'(nbits)}, {4'd3, 4'd7});
        frame_abort0 = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_n1", 32'(busy0), 1);
        @(negedge clk);
        check("abort_idle", 32'(busy0), 0);
        check("abort_outs", {ser_clk0, ser_data0, row_latch0, frame_done0, row_idx0}, 0);
        check("abort_addr", 32'(addr_b0), 0);
        @(posedge clk);
        #1 frame_req0 = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_blocks_req", 32'(busy0), 0);
        frame_req0 = 1'b0;
        check("abort_no_done", done_cnt - d0, 0);
        frame_abort0 = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy0), 0);
        do_frame(0);

        // asynchronous reset in the middle of SHIFT
        d0 = done_cnt;
        @(posedge clk);
        #1 frame_req0 = 1'b1;
        k = 0;
        while (k < 200) begin @(negedge clk); k++; if (ser_clk0) break; end
        frame_req0 = 1'b0;
        check("shift_reached", 32'(ser_clk0), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_outs", {ser_clk0, ser_data0, row_latch0, busy0, frame_done0, row_idx0}, 0);
        check("midrst_addr", 32'(addr_b0), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_idle", 32'(busy0), 0);
        check("midrst_no_done", done_cnt - d0, 0);

        // CLK_DIV=1, ROWS=2, BASE_ADDR=FFFF instance
        @(posedge clk);
        #1 frame_req1 = 1'b1;
        k = 0;
        while (k < 12) begin @(negedge clk); k++; if (busy1) break; end
        frame_req1 = 1'b0;
        check("d1_latency", k, 4);
        check("d1_start", {row_idx1, addr_b1}, {4'd0, 16'hFFFF});
        for (int c = 2; c <= 2 * ROW_CYC1 + 1; c++) begin
            @(negedge clk);
            if (c == ROW_CYC1)         check("d1_row0_latch", {row_latch1, addr_b1}, {1'b1, 16'hFFFF});
            if (c == ROW_CYC1 + 1)     check("d1_row1_fetch", {row_latch1, row_idx1, addr_b1}, {1'b0, 4'd1, 16'h0000});
            if (c == 2 * ROW_CYC1)     check("d1_before_done", {frame_done1, row_latch1}, 2'b01);
            if (c == 2 * ROW_CYC1 + 1) check("d1_done", {frame_done1, busy1}, 2'b11);
        end
        @(negedge clk);
        check("d1_idle", 32'(busy1), 0);

        check("serial_stability", stab_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
